// File: rtl/data_sram_wbuf.sv
// Single-port data SRAM fronted by an in-order store buffer. Stores are queued
// and drained on idle/stall cycles; loads merge pending stores byte by byte.
module data_sram_wbuf #(
  parameter int unsigned MEM_AW   = 10,
  parameter int unsigned WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stall_req
);

  localparam int unsigned PW    = $clog2(WB_DEPTH);
  localparam int unsigned CW    = PW + 1;
  localparam int unsigned DEPTH = 1 << MEM_AW;

  typedef struct packed {
    logic [MEM_AW-1:0] idx;
    logic [3:0]        wen;
    logic [31:0]       data;
  } wb_ent_t;

  logic [31:0]       r_mem [DEPTH];
  wb_ent_t           r_wb  [WB_DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic [MEM_AW-1:0] w_idx;
  logic              w_store;
  logic              w_load;
  logic              w_full;
  logic              w_append;
  logic              w_drain;
  logic [31:0]       w_merged;
  wb_ent_t           w_head_ent;
  logic              w_unused;

  assign w_idx      = data_sram_addr[MEM_AW+1:2];
  assign w_unused   = &{1'b0, data_sram_addr[31:MEM_AW+2], data_sram_addr[1:0]};
  assign w_store    = data_sram_en & (|data_sram_wen);
  assign w_load     = data_sram_en & ~(|data_sram_wen);
  assign w_full     = (r_count == CW'(WB_DEPTH));
  assign w_head_ent = r_wb[r_head];

  // Reset clears the buffer, so a store presented during reset never stalls.
  assign stall_req  = w_store & w_full & ~rst;
  assign w_append   = w_store & ~w_full & ~rst;
  assign w_drain    = (r_count != '0) & (~data_sram_en | stall_req) & ~rst;

  // RAM word overlaid with every matching pending store, oldest first.
  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < int'(WB_DEPTH); i++) begin
      if ((CW'(i) < r_count) && (r_wb[r_head + PW'(i)].idx == w_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (r_wb[r_head + PW'(i)].wen[b]) begin
            w_merged[8*b +: 8] = r_wb[r_head + PW'(i)].data[8*b +: 8];
          end
        end
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_drain) begin
      for (int b = 0; b < 4; b++) begin
        if (w_head_ent.wen[b]) begin
          r_mem[w_head_ent.idx][8*b +: 8] <= w_head_ent.data[8*b +: 8];
        end
      end
    end
    if (w_append) begin
      r_wb[r_tail] <= '{idx: w_idx, wen: data_sram_wen, data: data_sram_wdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head          <= '0;
      r_tail          <= '0;
      r_count         <= '0;
      data_sram_rdata <= 32'h0;
    end else begin
      if (w_append) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_drain) begin
        r_head <= r_head + PW'(1);
      end
      if (w_append && !w_drain) begin
        r_count <= r_count + CW'(1);
      end else if (w_drain && !w_append) begin
        r_count <= r_count - CW'(1);
      end
      if (w_load) begin
        data_sram_rdata <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_wbuf.sv
// Randomized bench for data_sram_wbuf: a memory-plus-pending-queue model is
// stepped on every falling edge and compared against the DUT outputs.
module tb_data_sram_wbuf;

  localparam int unsigned AW = 10;
  localparam int unsigned WB = 4;

  typedef struct {
    int          idx;
    logic [3:0]  wen;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        stall_req;

  data_sram_wbuf #(.MEM_AW(AW), .WB_DEPTH(WB)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .stall_req       (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: architectural RAM and the queue of not-yet-written stores.
  logic [31:0] m_ram [1024];
  ent_t        m_q [$];
  logic [31:0] m_rdata;
  bit          m_started;

  int n_checks;
  int n_errors;
  bit done;

  // Hand-computed expectations queued by the driver, checked by the compare process.
  string       lit_name [$];
  logic [31:0] lit_act  [$];
  logic [31:0] lit_exp  [$];

  function automatic logic [31:0] m_read(input int idx);
    logic [31:0] r;
    r = m_ram[idx];
    foreach (m_q[i]) begin
      if (m_q[i].idx == idx) begin
        for (int b = 0; b < 4; b++) begin
          if (m_q[i].wen[b]) r[8*b +: 8] = m_q[i].data[8*b +: 8];
        end
      end
    end
    return r;
  endfunction

  // Compare process: check outputs, then advance the model with the inputs
  // the DUT will sample at the next rising edge.
  initial begin
    int   lit_rd;
    int   idx;
    bit   st;
    bit   stl;
    logic exp_stall;
    ent_t e;
    n_checks  = 0;
    n_errors  = 0;
    lit_rd    = 0;
    m_started = 0;
    m_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (m_started) begin
        exp_stall = data_sram_en && (data_sram_wen != 4'h0) && (m_q.size() == WB) && !rst;
        n_checks++;
        if (stall_req !== exp_stall) begin
          n_errors++;
          $display("FAIL stall_req t=%0t got %0b want %0b", $time, stall_req, exp_stall);
        end
        n_checks++;
        if (data_sram_rdata !== m_rdata) begin
          n_errors++;
          $display("FAIL rdata t=%0t got %08h want %08h", $time, data_sram_rdata, m_rdata);
        end
        n_checks++;
        if (32'(dut.r_count) !== 32'(m_q.size())) begin
          n_errors++;
          $display("FAIL count t=%0t got %0d want %0d", $time, dut.r_count, m_q.size());
        end
      end
      while (lit_rd < lit_name.size()) begin
        n_checks++;
        if (lit_act[lit_rd] !== lit_exp[lit_rd]) begin
          n_errors++;
          $display("FAIL %s got %08h want %08h", lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
        end
        lit_rd++;
      end
      if (done) begin
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
      // Model step.
      if (rst) begin
        m_q.delete();
        m_rdata   = 32'h0;
        m_started = 1;
      end else begin
        idx = int'(data_sram_addr[11:2]);
        st  = data_sram_en && (data_sram_wen != 4'h0);
        stl = st && (m_q.size() == WB);
        if (data_sram_en && data_sram_wen == 4'h0) m_rdata = m_read(idx);
        if (m_q.size() > 0 && (!data_sram_en || stl)) begin
          e = m_q.pop_front();
          for (int b = 0; b < 4; b++) begin
            if (e.wen[b]) m_ram[e.idx][8*b +: 8] = e.data[8*b +: 8];
          end
        end
        if (st && !stl) m_q.push_back('{idx, data_sram_wen, data_sram_wdata});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic lit(input string n, input logic [31:0] a, input logic [31:0] e);
    lit_name.push_back(n);
    lit_act.push_back(a);
    lit_exp.push_back(e);
  endtask

  task automatic idle(input int n);
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load(input logic [31:0] a);
    data_sram_en   = 1'b1;
    data_sram_wen  = 4'h0;
    data_sram_addr = a;
    @(posedge clk); #1;
    data_sram_en   = 1'b0;
  endtask

  // Present a store and hold it while the DUT stalls it.
  task automatic store(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    data_sram_en    = 1'b1;
    data_sram_wen   = w;
    data_sram_addr  = a;
    data_sram_wdata = d;
    #1;
    for (int k = 0; k < 3 && stall_req; k++) begin
      @(posedge clk); #1;
    end
    if (stall_req) lit("stall_bound", 32'h1, 32'h0);
    @(posedge clk); #1;
    data_sram_en  = 1'b0;
    data_sram_wen = 4'h0;
  endtask

  function automatic logic [31:0] rand_addr(input int word);
    logic [31:0] t;
    t = $urandom();
    return {t[31:12], 10'(word), t[1:0]};
  endfunction

  initial begin
    logic [31:0] a;
    done            = 0;
    rst             = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_wen   = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    lit("reset_count", 32'(dut.r_count), 32'h0);
    lit("reset_rdata", data_sram_rdata, 32'h0);

    // Give every word used below a known value.
    for (int w = 0; w < 32; w++) begin
      store(rand_addr(w), 4'hF, $urandom());
      idle(1);
    end
    idle(6);

    // Store-to-load forwarding and byte merge.
    store(32'h10, 4'hF, 32'h11223344);
    load(32'h10);
    lit("fwd_rdata", data_sram_rdata, 32'h11223344);
    lit("fwd_count", 32'(dut.r_count), 32'h1);
    store(32'h12, 4'b0100, 32'h00AA0000);
    load(32'h10);
    lit("merge_rdata", data_sram_rdata, 32'h11AA3344);
    idle(6);

    // Full buffer: fifth store stalls exactly one cycle.
    for (int i = 0; i < 4; i++) store(32'h20 + 32'(4*i), 4'hF, 32'hA0000000 + 32'(i));
    lit("full_count", 32'(dut.r_count), 32'h4);
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h30;
    data_sram_wdata = 32'hA0000004;
    #1;
    lit("stall_5th", 32'(stall_req), 32'h1);
    @(posedge clk); #1;
    lit("stall_count3", 32'(dut.r_count), 32'h3);
    lit("stall_clear", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    lit("stall_count4", 32'(dut.r_count), 32'h4);
    data_sram_en = 1'b0;
    for (int i = 0; i < 5; i++) load(32'h20 + 32'(4*i));
    lit("full_load30", data_sram_rdata, 32'hA0000004);
    idle(6);
    for (int i = 0; i < 5; i++) load(32'h20 + 32'(4*i));

    // Idle drain empties the buffer.
    for (int i = 0; i < 4; i++) store(32'h50 + 32'(4*i), 4'hF, $urandom());
    idle(4);
    lit("drain_count", 32'(dut.r_count), 32'h0);
    for (int i = 0; i < 4; i++) load(32'h50 + 32'(4*i));

    // Reset with a full buffer and a store presented: no stall, contents dropped.
    for (int i = 0; i < 4; i++) store(32'h60 + 32'(4*i), 4'hF, $urandom());
    data_sram_en    = 1'b1;
    data_sram_wen   = 4'hF;
    data_sram_addr  = 32'h70;
    data_sram_wdata = 32'hDEADBEEF;
    rst             = 1'b1;
    #1;
    lit("rst_stall", 32'(stall_req), 32'h0);
    @(posedge clk); #1;
    rst          = 1'b0;
    data_sram_en = 1'b0;
    lit("rst_count_full", 32'(dut.r_count), 32'h0);
    for (int i = 0; i < 5; i++) load(32'h60 + 32'(4*i));

    // Reset mid-operation with three buffered stores.
    load(32'h10);
    for (int i = 0; i < 3; i++) store(32'h40 + 32'(4*i), 4'hF, $urandom());
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    lit("rst_count", 32'(dut.r_count), 32'h0);
    lit("rst_rdata", data_sram_rdata, 32'h0);
    for (int i = 0; i < 3; i++) load(32'h40 + 32'(4*i));

    // Pointer wrap: ten stores to three words interleaved with idles.
    for (int i = 0; i < 10; i++) begin
      store(rand_addr(26 + (i % 3)), 4'(i + 1), $urandom());
      idle(i % 2);
      load(rand_addr(26 + (i % 3)));
    end
    for (int w = 26; w < 29; w++) load(rand_addr(w));

    // Randomized traffic over 32 words.
    for (int n = 0; n < 800; n++) begin
      int r;
      r = int'($urandom_range(0, 99));
      a = rand_addr(int'($urandom_range(0, 31)));
      if (r < 1) begin
        rst          = 1'b1;
        data_sram_en = $urandom_range(0, 1) == 1;
        data_sram_wen = 4'($urandom_range(0, 15));
        @(posedge clk); #1;
        rst = 1'b0;
        data_sram_en = 1'b0;
      end else if (r < 45) begin
        store(a, 4'($urandom_range(1, 15)), $urandom());
      end else if (r < 75) begin
        load(a);
      end else begin
        idle(1);
      end
    end
    idle(6);
    for (int w = 0; w < 32; w++) load(rand_addr(w));

    idle(1);
    done = 1;
  end

endmodule
